// File: rtl/snow2_stream_xor.sv
// snow2_stream_xor: keystream consumer for a SNOW 2.0 generator.
// Buffers 32-bit keystream words in a FIFO and XORs one word onto each data
// word; the same path encrypts and decrypts. Warm-up words after each start
// are discarded, processed words are counted and FIFO overflow is flagged.
// Optional byte-keep support is enabled by defining SNOW2_XOR_KEEP_EN.
module snow2_stream_xor #(
    parameter int FIFO_DEPTH    = 8,
    parameter int DISCARD_WORDS = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        ks_valid,
    input  logic [31:0] keystream,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [31:0] din,
`ifdef SNOW2_XOR_KEEP_EN
    input  logic [3:0]  din_keep,
    output logic [3:0]  dout_keep,
`endif
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [31:0] dout,
    output logic        busy,
    output logic        ks_ovf,
    output logic [31:0] word_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISCARD = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t state, state_next;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    discard_cnt;

    logic        fifo_empty;
    logic        fifo_full;
    logic        push_req;
    logic        do_push;
    logic        din_accept;
    logic        dout_accept;
    logic [31:0] head;
    logic [31:0] xor_word;

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == FULL_CNT);
    assign head        = mem[rd_ptr];
    assign din_accept  = din_valid & din_ready;
    assign dout_accept = dout_valid & dout_ready;
    // A keystream word in the start cycle belongs to the old message and is ignored.
    assign push_req    = (state == RUN) & ks_valid & ~start;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign do_push     = push_req & (~fifo_full | din_accept);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start always restarts; DISCARD leaves after the last dropped word.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = (DISCARD_WORDS == 0) ? RUN : DISCARD;
        end else begin
            case (state)
                DISCARD: if (ks_valid && discard_cnt <= 8'd1) state_next = RUN;
                default: state_next = state;
            endcase
        end
    end

    // Output decode from state: busy flag and the combinational input handshake.
    always_comb begin
        busy      = (state != IDLE);
        din_ready = (state == RUN) & ~fifo_empty & (~dout_valid | dout_ready);
    end

    // Warm-up counter: loaded on start, counts keystream words dropped in DISCARD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            discard_cnt <= '0;
        end else if (start) begin
            discard_cnt <= 8'(DISCARD_WORDS);
        end else if (state == DISCARD && ks_valid && discard_cnt != '0) begin
            discard_cnt <= discard_cnt - 8'd1;
        end
    end

    // Keystream storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= keystream;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag; start flushes all of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ks_ovf <= 1'b0;
        end else if (start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ks_ovf <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (din_accept) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, din_accept})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push_req && fifo_full && !din_accept) begin
                ks_ovf <= 1'b1;
            end
        end
    end

    // Combine the data word with the FIFO head, zeroing bytes that are not kept.
    always_comb begin
        xor_word = din ^ head;
`ifdef SNOW2_XOR_KEEP_EN
        for (int i = 0; i < 4; i++) begin
            if (!din_keep[i]) begin
                xor_word[8*i +: 8] = 8'h00;
            end
        end
`endif
    end

    // Output register: loads on a data accept, holds under backpressure, empties on drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
`ifdef SNOW2_XOR_KEEP_EN
            dout_keep  <= '0;
`endif
        end else if (start) begin
            dout_valid <= 1'b0;
        end else if (din_accept) begin
            dout       <= xor_word;
            dout_valid <= 1'b1;
`ifdef SNOW2_XOR_KEEP_EN
            dout_keep  <= din_keep;
`endif
        end else if (dout_accept) begin
            dout_valid <= 1'b0;
        end
    end

    // Count of output words taken downstream since the last start; wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (start) begin
            word_cnt <= '0;
        end else if (dout_accept) begin
            word_cnt <= word_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_snow2_stream_xor.sv
// tb_snow2_stream_xor: directed bench for snow2_stream_xor.
// One instance with DISCARD_WORDS=0 and one with DISCARD_WORDS=2 share the clock.
module tb_snow2_stream_xor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, ks_valid, din_valid, dout_ready;
    logic [31:0] keystream, din;
    logic        din_ready, dout_valid, busy, ks_ovf;
    logic [31:0] dout, word_cnt;

    logic        b_start, b_ks_valid, b_din_valid, b_dout_ready;
    logic [31:0] b_keystream, b_din;
    logic        b_din_ready, b_dout_valid, b_busy, b_ks_ovf;
    logic [31:0] b_dout, b_word_cnt;

`ifdef SNOW2_XOR_KEEP_EN
    logic [3:0] din_keep, dout_keep, b_din_keep, b_dout_keep;
`endif

    int checks   = 0;
    int failures = 0;

    snow2_stream_xor #(.FIFO_DEPTH(8), .DISCARD_WORDS(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ks_valid(ks_valid), .keystream(keystream),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
`ifdef SNOW2_XOR_KEEP_EN
        .din_keep(din_keep), .dout_keep(dout_keep),
`endif
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
        .busy(busy), .ks_ovf(ks_ovf), .word_cnt(word_cnt)
    );

    snow2_stream_xor #(.FIFO_DEPTH(8), .DISCARD_WORDS(2)) dut_discard (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .ks_valid(b_ks_valid), .keystream(b_keystream),
        .din_valid(b_din_valid), .din_ready(b_din_ready), .din(b_din),
`ifdef SNOW2_XOR_KEEP_EN
        .din_keep(b_din_keep), .dout_keep(b_dout_keep),
`endif
        .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .dout(b_dout),
        .busy(b_busy), .ks_ovf(b_ks_ovf), .word_cnt(b_word_cnt)
    );

    typedef struct {
        logic        start;
        logic        ks_valid;
        logic [31:0] ks;
        logic        din_valid;
        logic [31:0] din;
        logic        dout_ready;
        logic        e_din_ready;
        logic        e_dout_valid;
        logic [31:0] e_dout;
        logic        e_ovf;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Record one comparison and report it when it does not hold.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Drive the inputs of the DISCARD_WORDS=0 instance.
    task automatic applyStimulus(input logic s, input logic kv, input logic [31:0] ks,
                                 input logic dv, input logic [31:0] d, input logic dr);
        start      = s;
        ks_valid   = kv;
        keystream  = ks;
        din_valid  = dv;
        din        = d;
        dout_ready = dr;
    endtask

    // Drive the inputs of the DISCARD_WORDS=2 instance.
    task automatic applyStimulusB(input logic s, input logic kv, input logic [31:0] ks,
                                  input logic dv, input logic [31:0] d, input logic dr);
        b_start      = s;
        b_ks_valid   = kv;
        b_keystream  = ks;
        b_din_valid  = dv;
        b_din        = d;
        b_dout_ready = dr;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic add_row(input logic s, input logic kv, input logic [31:0] ks,
                           input logic dv, input logic [31:0] d, input logic dr,
                           input logic erdy, input logic edv, input logic [31:0] edout,
                           input logic eovf, input logic [31:0] ecnt);
        vec_t v;
        v.start = s; v.ks_valid = kv; v.ks = ks; v.din_valid = dv; v.din = d; v.dout_ready = dr;
        v.e_din_ready = erdy; v.e_dout_valid = edv; v.e_dout = edout; v.e_ovf = eovf; v.e_cnt = ecnt;
        vecs.push_back(v);
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] drain_seq [9];

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulusB(0, 0, 0, 0, 0, 0);
`ifdef SNOW2_XOR_KEEP_EN
        din_keep   = 4'hF;
        b_din_keep = 4'hF;
`endif
        advance();
        advance();

        // Reset state
        settle();
        checkOutput("reset dout_valid", dout_valid, 0);
        checkOutput("reset dout", dout, 0);
        checkOutput("reset din_ready", din_ready, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset ks_ovf", ks_ovf, 0);
        checkOutput("reset word_cnt", word_cnt, 0);
        rst_n = 1'b1;
        advance();

        // Warm-up discard: A and B dropped, C used for the first word
        applyStimulusB(1, 0, 0, 0, 0, 0);
        settle();
        checkOutput("disc idle busy", b_busy, 0);
        advance();
        applyStimulusB(0, 1, 32'hA0A0A0A0, 0, 0, 0);
        settle();
        checkOutput("disc busy", b_busy, 1);
        checkOutput("disc din_ready A", b_din_ready, 0);
        advance();
        applyStimulusB(0, 1, 32'hB0B0B0B0, 0, 0, 0);
        settle();
        checkOutput("disc din_ready B", b_din_ready, 0);
        advance();
        applyStimulusB(0, 1, 32'hC0C0C0C0, 0, 0, 0);
        settle();
        checkOutput("disc din_ready C", b_din_ready, 0);
        advance();
        applyStimulusB(0, 0, 0, 1, 32'h0, 1);
        settle();
        checkOutput("disc din_ready run", b_din_ready, 1);
        advance();
        applyStimulusB(0, 0, 0, 0, 0, 1);
        settle();
        checkOutput("disc dout_valid", b_dout_valid, 1);
        checkOutput("disc dout", b_dout, 32'hC0C0C0C0);
        advance();
        applyStimulusB(0, 0, 0, 0, 0, 0);
        settle();
        checkOutput("disc fifo empty", b_din_ready, 0);
        checkOutput("disc word_cnt", b_word_cnt, 1);
        advance();

        // Table: basic XOR, prefill to full, full-rate streaming, drain
        add_row(1, 0, 0,            0, 0,            0, 0, 0, 0,            0, 0);
        add_row(0, 1, 32'h11111111, 0, 0,            0, 0, 0, 0,            0, 0);
        add_row(0, 0, 0,            1, 32'hFFFFFFFF, 1, 1, 0, 0,            0, 0);
        add_row(0, 0, 0,            0, 0,            1, 0, 1, 32'hEEEEEEEE, 0, 0);
        add_row(0, 0, 0,            0, 0,            0, 0, 0, 0,            0, 1);
        for (int k = 0; k < 8; k++)
            add_row(0, 1, 32'h00001000 + k, 0, 0, 0, (k > 0), 0, 0, 0, 1);
        for (int k = 0; k < 8; k++)
            add_row(0, 1, 32'h20000000 + k, 1, 32'hF0F00000 + k*16, 1, 1, (k > 0),
                    (32'hF0F00000 + (k-1)*16) ^ (32'h00001000 + k - 1), 0, (k == 0) ? 1 : k);
        add_row(0, 0, 0, 0, 0, 1, 1, 1, (32'hF0F00000 + 7*16) ^ 32'h00001007, 0, 8);
        add_row(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 9);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].start, vecs[i].ks_valid, vecs[i].ks,
                          vecs[i].din_valid, vecs[i].din, vecs[i].dout_ready);
            settle();
            checkOutput($sformatf("row%0d din_ready", i), din_ready, vecs[i].e_din_ready);
            checkOutput($sformatf("row%0d dout_valid", i), dout_valid, vecs[i].e_dout_valid);
            if (vecs[i].e_dout_valid)
                checkOutput($sformatf("row%0d dout", i), dout, vecs[i].e_dout);
            checkOutput($sformatf("row%0d ks_ovf", i), ks_ovf, vecs[i].e_ovf);
            checkOutput($sformatf("row%0d word_cnt", i), word_cnt, vecs[i].e_cnt);
            advance();
        end

        // Backpressure hold with overflow, then in-order drain
        applyStimulus(0, 0, 0, 1, 32'h0, 0);
        settle();
        checkOutput("hold load din_ready", din_ready, 1);
        advance();
        for (int h = 0; h < 5; h++) begin
            applyStimulus(0, (h < 2), 32'h30000000 + h, 1, 32'h12345678, 0);
            settle();
            checkOutput($sformatf("hold%0d din_ready", h), din_ready, 0);
            checkOutput($sformatf("hold%0d dout_valid", h), dout_valid, 1);
            checkOutput($sformatf("hold%0d dout", h), dout, 32'h20000000);
            checkOutput($sformatf("hold%0d ks_ovf", h), ks_ovf, (h >= 2));
            advance();
        end
        for (int j = 0; j < 8; j++) drain_seq[j] = 32'h20000000 + j;
        drain_seq[8] = 32'h30000000;
        for (int j = 0; j < 9; j++) begin
            applyStimulus(0, 0, 0, 1, 32'h0, 1);
            settle();
            checkOutput($sformatf("drain%0d dout_valid", j), dout_valid, 1);
            checkOutput($sformatf("drain%0d dout", j), dout, drain_seq[j]);
            checkOutput($sformatf("drain%0d din_ready", j), din_ready, (j < 8));
            advance();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        settle();
        checkOutput("drain end dout_valid", dout_valid, 0);
        checkOutput("drain end word_cnt", word_cnt, 18);
        checkOutput("drain end ks_ovf", ks_ovf, 1);
        advance();

        // Restart in the middle of RUN with a pending output word
        applyStimulus(0, 1, 32'h40000000, 0, 0, 0);
        advance();
        applyStimulus(0, 1, 32'h40000001, 1, 32'h0, 0);
        settle();
        checkOutput("restart pre din_ready", din_ready, 1);
        advance();
        applyStimulus(1, 1, 32'hDEAD0000, 0, 0, 0);
        settle();
        checkOutput("restart pending dout_valid", dout_valid, 1);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0);
        settle();
        checkOutput("restart dout_valid", dout_valid, 0);
        checkOutput("restart word_cnt", word_cnt, 0);
        checkOutput("restart ks_ovf", ks_ovf, 0);
        checkOutput("restart fifo empty", din_ready, 0);
        checkOutput("restart busy", busy, 1);
        advance();
        applyStimulus(0, 1, 32'h55555555, 0, 0, 0);
        advance();
        applyStimulus(0, 0, 0, 1, 32'h0F0F0F0F, 1);
        settle();
        checkOutput("restart din_ready", din_ready, 1);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 1);
        settle();
        checkOutput("restart dout", dout, 32'h5A5A5A5A);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0);
        settle();
        checkOutput("restart word_cnt after", word_cnt, 1);
        checkOutput("restart second word absent", din_ready, 0);
        advance();

`ifdef SNOW2_XOR_KEEP_EN
        // Partial word with byte keep
        applyStimulus(1, 0, 0, 0, 0, 0);
        advance();
        applyStimulus(0, 1, 32'h0F0F0F0F, 0, 0, 0);
        advance();
        applyStimulus(0, 0, 0, 1, 32'hAABBCCDD, 1);
        din_keep = 4'b0011;
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0);
        din_keep = 4'hF;
        settle();
        checkOutput("keep dout", dout, 32'h0000C3D2);
        checkOutput("keep dout_keep", dout_keep, 4'b0011);
        advance();
`endif

        // Reset overrides start and handshakes in the same cycle
        applyStimulus(1, 1, 32'h77777777, 1, 32'h1, 1);
        rst_n = 1'b0;
        advance();
        settle();
        checkOutput("rst override busy", busy, 0);
        checkOutput("rst override dout_valid", dout_valid, 0);
        checkOutput("rst override dout", dout, 0);
        checkOutput("rst override word_cnt", word_cnt, 0);
        checkOutput("rst override din_ready", din_ready, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        advance();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
